decoder_nx: RTL and testbench

Parametrised registered N-to-2^N one-hot decoder, the successor to the fixed 3-to-8 combinational decoder. It adds:

- a registered output with a load strobe and update pulse,
- an output enable,
- selectable output polarity,
- an optional scan mode that walks the active line up or down with wrap detection.

It is used for chip-select and row/column strobing in the DMG address and LCD paths.

---
 rtl/decoder_nx.sv | 92 +++++++++
 tb/tb_decoder_nx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/decoder_nx.sv
// Registered N-to-2^N one-hot decoder with load strobe, output enable and polarity select.
// Optional scan mode (walk the active line up/down with wrap pulse) is enabled by DECODER_NX_SCAN_EN.
module decoder_nx #(
   parameter  int SEL_W      = 3,
   parameter  bit ACTIVE_LOW = 1'b0,
   localparam int OUT_N      = 2 ** SEL_W
) (
   input  logic             i_CLK,
   input  logic             i_RST,
   input  logic             i_EN,
   input  logic             i_LOAD,
   input  logic [SEL_W-1:0] i_SEL,
   input  logic             i_MODE,
   input  logic             i_STEP,
   input  logic             i_DIR,
   output logic [OUT_N-1:0] o_OUT,
   output logic [SEL_W-1:0] o_IDX,
   output logic             o_UPD,
   output logic             o_WRAP
);

   localparam logic [OUT_N-1:0] OUT_IDLE = {OUT_N{ACTIVE_LOW}};
   localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
   localparam logic [SEL_W-1:0] IDX_MAX  = {SEL_W{1'b1}};

   generate
      if (SEL_W < 1 || SEL_W > 6) begin : g_bad_width
         $error("decoder_nx: SEL_W must be in 1..6");
      end
   endgenerate

   logic [SEL_W-1:0] idx_q, idx_d;
   logic [OUT_N-1:0] out_q, out_d;
   logic             upd_q, upd_d;
   logic             wrap_q, wrap_d;
   logic [OUT_N-1:0] onehot;

   // Load always wins over a step; a step only exists in scan mode.
   always_comb begin
      idx_d  = idx_q;
      upd_d  = 1'b0;
      wrap_d = 1'b0;
      if (i_LOAD) begin
         idx_d = i_SEL;
         upd_d = 1'b1;
      end
`ifdef DECODER_NX_SCAN_EN
      else if (i_MODE && i_STEP) begin
         upd_d = 1'b1;
         if (!i_DIR) begin
            idx_d  = idx_q + IDX_ONE;
            wrap_d = (idx_q == IDX_MAX);
         end else begin
            idx_d  = idx_q - IDX_ONE;
            wrap_d = (idx_q == '0);
         end
      end
`endif
   end

   // Outputs decode the next index so they track idx with the same one-cycle latency.
   always_comb begin
      onehot        = '0;
      onehot[idx_d] = 1'b1;
      out_d         = (i_EN ? onehot : '0) ^ OUT_IDLE;
   end

`ifndef DECODER_NX_SCAN_EN
   logic unused_scan_inputs;
   assign unused_scan_inputs = ^{i_MODE, i_STEP, i_DIR};
`endif

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         idx_q  <= '0;
         out_q  <= OUT_IDLE;
         upd_q  <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         out_q  <= out_d;
         upd_q  <= upd_d;
         wrap_q <= wrap_d;
      end
   end

   assign o_OUT  = out_q;
   assign o_IDX  = idx_q;
   assign o_UPD  = upd_q;
   assign o_WRAP = wrap_q;

endmodule

// File: tb/tb_decoder_nx.sv
// Directed self-checking bench for decoder_nx: an 8-line active-high instance and a 16-line active-low instance.
// Scan checks follow DECODER_NX_SCAN_EN; without it the bench checks that scan inputs are ignored.
module tb_decoder_nx;

   logic        clock = 1'b0;
   logic        reset;
   logic        en, load, mode, step, dir;
   logic [2:0]  sel3;
   logic [3:0]  sel4;
   logic [7:0]  out3;
   logic [2:0]  idx3;
   logic        upd3, wrap3;
   logic [15:0] out4;
   logic [3:0]  idx4;
   logic        upd4, wrap4;

   int checkCount = 0;
   int failCount  = 0;

   always #5 clock = ~clock;

   decoder_nx #(.SEL_W(3), .ACTIVE_LOW(1'b0)) dutHigh (
      .i_CLK(clock), .i_RST(reset), .i_EN(en), .i_LOAD(load), .i_SEL(sel3),
      .i_MODE(mode), .i_STEP(step), .i_DIR(dir),
      .o_OUT(out3), .o_IDX(idx3), .o_UPD(upd3), .o_WRAP(wrap3)
   );

   decoder_nx #(.SEL_W(4), .ACTIVE_LOW(1'b1)) dutLow (
      .i_CLK(clock), .i_RST(reset), .i_EN(en), .i_LOAD(load), .i_SEL(sel4),
      .i_MODE(mode), .i_STEP(step), .i_DIR(dir),
      .o_OUT(out4), .o_IDX(idx4), .o_UPD(upd4), .o_WRAP(wrap4)
   );

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Drive one set of inputs, then let one edge pass and settle just after it.
   task automatic applyStimulus(input logic l, input logic [3:0] s, input logic m,
                                input logic st, input logic d, input logic e);
      load = l;
      sel3 = s[2:0];
      sel4 = s;
      mode = m;
      step = st;
      dir  = d;
      en   = e;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      en = 1'b1; load = 1'b0; mode = 1'b0; step = 1'b0; dir = 1'b0;
      sel3 = '0; sel4 = '0;
      @(posedge clock);
      @(posedge clock);
      #1;
      checkOutput("rst_out3", 64'(out3), 64'h00);
      checkOutput("rst_idx3", 64'(idx3), 64'd0);
      checkOutput("rst_upd3", 64'(upd3), 64'd0);
      checkOutput("rst_wrap3", 64'(wrap3), 64'd0);
      checkOutput("rst_out4", 64'(out4), 64'hFFFF);

      reset = 1'b0;
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("first_edge_out3", 64'(out3), 64'h01);
      checkOutput("first_edge_upd3", 64'(upd3), 64'd0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput($sformatf("sweep_out_%0d", i), 64'(out3), 64'(8'h01 << i));
         checkOutput($sformatf("sweep_idx_%0d", i), 64'(idx3), 64'(i));
         checkOutput($sformatf("sweep_upd_%0d", i), 64'(upd3), 64'd1);
      end
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("sweep_upd_drop", 64'(upd3), 64'd0);
      checkOutput("sweep_hold_out", 64'(out3), 64'h80);

      applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      load = 1'b0;
      checkOutput("pre_rst_idx3", 64'(idx3), 64'd5);
      checkOutput("pre_rst_upd3", 64'(upd3), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_out3", 64'(out3), 64'h00);
      checkOutput("async_rst_idx3", 64'(idx3), 64'd0);
      checkOutput("async_rst_upd3", 64'(upd3), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("post_rst_out3", 64'(out3), 64'h01);

      applyStimulus(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("pol_out4", 64'(out4), 64'hFDFF);
      checkOutput("pol_idx4", 64'(idx4), 64'd9);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("dis_out4", 64'(out4), 64'hFFFF);
      checkOutput("dis_idx4", 64'(idx4), 64'd9);
      checkOutput("dis_out3", 64'(out3), 64'h00);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("reen_out4", 64'(out4), 64'hFDFF);

`ifdef DECODER_NX_SCAN_EN
      applyStimulus(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("up1_idx", 64'(idx3), 64'd7);
      checkOutput("up1_wrap", 64'(wrap3), 64'd0);
      checkOutput("up1_out", 64'(out3), 64'h80);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("up2_idx", 64'(idx3), 64'd0);
      checkOutput("up2_wrap", 64'(wrap3), 64'd1);
      checkOutput("up2_upd", 64'(upd3), 64'd1);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("up3_idx", 64'(idx3), 64'd1);
      checkOutput("up3_wrap", 64'(wrap3), 64'd0);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("dn1_idx", 64'(idx3), 64'd0);
      checkOutput("dn1_wrap", 64'(wrap3), 64'd0);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("dn2_idx", 64'(idx3), 64'd7);
      checkOutput("dn2_wrap", 64'(wrap3), 64'd1);
      checkOutput("dn2_out", 64'(out3), 64'h80);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("idle_upd", 64'(upd3), 64'd0);
      checkOutput("idle_wrap", 64'(wrap3), 64'd0);

      applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("ldstep_idx", 64'(idx3), 64'd7);
      checkOutput("ldstep_wrap", 64'(wrap3), 64'd0);
      checkOutput("ldstep_upd", 64'(upd3), 64'd1);

      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("decode_step_idx", 64'(idx3), 64'd7);
      checkOutput("decode_step_upd", 64'(upd3), 64'd0);
`else
      applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'(i), 1'b1);
         checkOutput($sformatf("noscan_idx_%0d", i), 64'(idx3), 64'd3);
         checkOutput($sformatf("noscan_upd_%0d", i), 64'(upd3), 64'd0);
         checkOutput($sformatf("noscan_wrap_%0d", i), 64'(wrap3), 64'd0);
         checkOutput($sformatf("noscan_out_%0d", i), 64'(out3), 64'h08);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
